// File: rtl/opl3_pkg.sv
// Shared constants and types for the OPL3 interval timers.
package opl3_pkg;

  // Counter and preset width used by both timers.
  localparam int TIMER_WIDTH = 8;

  // Tick prescale factors: timer 1 counts every 80 us tick, timer 2 every fourth.
  localparam int TIMER1_PRESCALE = 1;
  localparam int TIMER2_PRESCALE = 4;

  // Timer run state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

endpackage

// File: rtl/opl3_timer_tick_prescaler.sv
// Divides the incoming tick_en stream by TICK_PRESCALE.
// inc_en fires on the tick that completes a prescale period.
module tick_prescaler #(
  parameter int TICK_PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick_en,
  output logic inc_en
);

  // A 1-bit counter is kept even for prescale 1 so the port stays uniform.
  localparam int PS_W = (TICK_PRESCALE > 1) ? $clog2(TICK_PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_PRESCALE - 1);

  logic [PS_W-1:0] ps_cnt_reg;
  logic [PS_W-1:0] ps_cnt_next;
  logic            at_last;

  assign at_last = (ps_cnt_reg == PS_LAST);

  // clear holds the counter at zero and suppresses increments entirely.
  assign inc_en = tick_en & at_last & ~clear;

  // Next prescale count: clear wins, otherwise advance and wrap on each tick.
  always_comb begin
    ps_cnt_next = ps_cnt_reg;
    if (clear) begin
      ps_cnt_next = '0;
    end else if (tick_en) begin
      if (at_last) begin
        ps_cnt_next = '0;
      end else begin
        ps_cnt_next = ps_cnt_reg + PS_W'(1);
      end
    end
  end

  // Prescale counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt_reg <= '0;
    end else begin
      ps_cnt_reg <= ps_cnt_next;
    end
  end

endmodule

// File: rtl/opl3_timer.sv
// OPL3 interval timer: counts up from a preset on prescaled ticks, reloads
// the preset on overflow, strobes overflow and latches a maskable flag.
module opl3_timer #(
  parameter int TICK_PRESCALE = 1,
  parameter int TIMER_WIDTH   = opl3_pkg::TIMER_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_en,
  input  logic                   start,
  input  logic [TIMER_WIDTH-1:0] preset,
  input  logic                   mask,
  input  logic                   clear_flag,
  output logic [TIMER_WIDTH-1:0] count,
  output logic                   overflow,
  output logic                   flag
);

  import opl3_pkg::*;

  localparam logic [TIMER_WIDTH-1:0] COUNT_MAX = '1;

  timer_state_t           state_reg;
  timer_state_t           state_next;
  logic [TIMER_WIDTH-1:0] count_reg;
  logic [TIMER_WIDTH-1:0] count_next;
  logic                   overflow_reg;
  logic                   overflow_next;
  logic                   flag_reg;
  logic                   flag_next;
  logic                   inc_en;
  logic                   wrap;

  // The prescaler only runs in RUN; in IDLE it is held cleared so a restart
  // always begins a fresh prescale period.
  tick_prescaler #(
    .TICK_PRESCALE(TICK_PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_reg != RUN),
    .tick_en(tick_en),
    .inc_en (inc_en)
  );

  // An increment from all-ones is an overflow (reload instead of wrapping).
  assign wrap = inc_en & (count_reg == COUNT_MAX);

  // Next-state logic for FSM, counter, overflow strobe and sticky flag.
  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    overflow_next = wrap;
    flag_next     = flag_reg;

    if (state_reg == IDLE) begin
      // Keep tracking the preset so RUN starts from the latest value.
      count_next = preset;
      if (start) begin
        state_next = RUN;
      end
    end else begin
      if (!start) begin
        state_next = IDLE;
      end
      if (inc_en) begin
        count_next = wrap ? preset : (count_reg + TIMER_WIDTH'(1));
      end
    end

    // A simultaneous set and clear leaves the flag set.
    if (wrap && !mask) begin
      flag_next = 1'b1;
    end else if (clear_flag) begin
      flag_next = 1'b0;
    end
  end

  // State registers; reset overrides all other inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      flag_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      flag_reg     <= flag_next;
    end
  end

  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign flag     = flag_reg;

endmodule

// File: tb/tb_opl3_timer.sv
// Directed bench for opl3_timer: timer 1 (prescale 1) and timer 2 (prescale 4)
// share tick/mask/clear/reset; expectations are queued per cycle and compared
// after the clock edge.
module tb_opl3_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick_en = 1'b0;
  logic       mask = 1'b0;
  logic       clear_flag = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [7:0] preset1 = 8'd0;
  logic [7:0] preset2 = 8'd0;
  logic [7:0] count1, count2;
  logic       overflow1, overflow2, flag1, flag2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    int         which;
    logic [7:0] c;
    logic       o;
    logic       f;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  opl3_timer #(.TICK_PRESCALE(1), .TIMER_WIDTH(8)) dut1 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .start(start1),
    .preset(preset1), .mask(mask), .clear_flag(clear_flag),
    .count(count1), .overflow(overflow1), .flag(flag1)
  );

  opl3_timer #(.TICK_PRESCALE(4), .TIMER_WIDTH(8)) dut2 (
    .clk(clk), .reset(reset), .tick_en(tick_en), .start(start2),
    .preset(preset2), .mask(mask), .clear_flag(clear_flag),
    .count(count2), .overflow(overflow2), .flag(flag2)
  );

  // One clock cycle: drive tick, queue the expectation, clock, pop and compare.
  task automatic cyc(input logic t, input string tag, input int which,
                     input logic [7:0] c, input logic o, input logic f);
    exp_t e;
    logic [7:0] gc;
    logic go, gf;
    tick_en = t;
    sb.push_back('{tag, which, c, o, f});
    @(posedge clk);
    #1;
    e  = sb.pop_front();
    gc = (e.which == 1) ? count1 : count2;
    go = (e.which == 1) ? overflow1 : overflow2;
    gf = (e.which == 1) ? flag1 : flag2;
    checks++;
    assert (gc === e.c) else begin
      errors++;
      $error("FAIL %s t%0d count got %0d want %0d", e.tag, e.which, gc, e.c);
    end
    checks++;
    assert (go === e.o) else begin
      errors++;
      $error("FAIL %s t%0d overflow got %b want %b", e.tag, e.which, go, e.o);
    end
    checks++;
    assert (gf === e.f) else begin
      errors++;
      $error("FAIL %s t%0d flag got %b want %b", e.tag, e.which, gf, e.f);
    end
    $display("cyc %-10s t%0d tick=%b count=%0d ovf=%b flag=%b", e.tag, e.which, t, gc, go, gf);
    tick_en    = 1'b0;
    clear_flag = 1'b0;
    reset      = 1'b0;
  endtask

  // Idle cycles with no tick: outputs must hold and no overflow may appear.
  task automatic gap(input int n, input string tag, input int which,
                     input logic [7:0] c, input logic f);
    for (int k = 0; k < n; k++) cyc(1'b0, tag, which, c, 1'b0, f);
  endtask

  initial begin
    // Reset state for both timers
    cyc(1'b0, "reset", 1, 8'd0, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(1'b0, "reset", 2, 8'd0, 1'b0, 1'b0);

    // Timer 1 basic: preset 250, overflow after 6th tick
    preset1 = 8'd250;
    start1  = 1'b1;
    cyc(1'b0, "t1_load", 1, 8'd250, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, "t1_tick", 1, 8'(250 + i), 1'b0, 1'b0);
      gap(9, "t1_gap", 1, 8'(250 + i), 1'b0);
    end
    cyc(1'b1, "t1_ovf", 1, 8'd250, 1'b1, 1'b1);
    gap(3, "t1_post", 1, 8'd250, 1'b1);
    start1 = 1'b0;
    cyc(1'b0, "t1_stop", 1, 8'd250, 1'b0, 1'b1);
    cyc(1'b1, "t1_idle", 1, 8'd250, 1'b0, 1'b1);
    clear_flag = 1'b1;
    cyc(1'b0, "t1_clr", 1, 8'd250, 1'b0, 1'b0);

    // Timer 2 prescale 4: preset 254, first overflow after 8 ticks
    preset2 = 8'd254;
    start2  = 1'b1;
    cyc(1'b0, "t2_load", 2, 8'd254, 1'b0, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      cyc(1'b1, "t2_tick", 2, (j < 4) ? 8'd254 : ((j < 8) ? 8'd255 : 8'd254),
          (j == 8), (j == 8));
      gap(1, "t2_gap", 2, (j < 4) ? 8'd254 : ((j < 8) ? 8'd255 : 8'd254), (j == 8));
    end
    start2 = 1'b0;
    cyc(1'b0, "t2_stop", 2, 8'd254, 1'b0, 1'b1);
    clear_flag = 1'b1;
    cyc(1'b0, "t2_clr", 2, 8'd254, 1'b0, 1'b0);

    // Mask and clear on timer 1: preset 255 overflows on every tick
    mask    = 1'b1;
    preset1 = 8'd255;
    start1  = 1'b1;
    cyc(1'b0, "mk_load", 1, 8'd255, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, "mk_ovf", 1, 8'd255, 1'b1, 1'b0);
      gap(1, "mk_gap", 1, 8'd255, 1'b0);
    end
    mask = 1'b0;
    cyc(1'b1, "mk_unmask", 1, 8'd255, 1'b1, 1'b1);
    gap(1, "mk_gap", 1, 8'd255, 1'b1);
    clear_flag = 1'b1;
    cyc(1'b1, "set_win", 1, 8'd255, 1'b1, 1'b1);
    gap(1, "mk_gap", 1, 8'd255, 1'b1);
    clear_flag = 1'b1;
    cyc(1'b0, "clr_only", 1, 8'd255, 1'b0, 1'b0);

    // Stop/restart: preset 0, 100 ticks, stop, ignored ticks, restart at 200
    start1 = 1'b0;
    cyc(1'b0, "sr_stop", 1, 8'd255, 1'b0, 1'b0);
    preset1 = 8'd0;
    cyc(1'b0, "sr_load", 1, 8'd0, 1'b0, 1'b0);
    start1 = 1'b1;
    cyc(1'b0, "sr_start", 1, 8'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 100; i++) cyc(1'b1, "sr_tick", 1, 8'(i), 1'b0, 1'b0);
    start1 = 1'b0;
    cyc(1'b0, "sr_stop", 1, 8'd100, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, "sr_ignore", 1, 8'd0, 1'b0, 1'b0);
    preset1 = 8'd200;
    start1  = 1'b1;
    cyc(1'b0, "sr_restart", 1, 8'd200, 1'b0, 1'b0);
    for (int i = 1; i <= 55; i++) cyc(1'b1, "sr_tick", 1, 8'(200 + i), 1'b0, 1'b0);
    cyc(1'b1, "sr_ovf56", 1, 8'd200, 1'b1, 1'b1);
    gap(1, "sr_gap", 1, 8'd200, 1'b1);

    // Reset mid-operation at count 254, coincident with a tick
    for (int i = 1; i <= 54; i++) cyc(1'b1, "rm_tick", 1, 8'(200 + i), 1'b0, 1'b1);
    reset = 1'b1;
    cyc(1'b1, "rm_reset", 1, 8'd0, 1'b0, 1'b0);
    cyc(1'b0, "rm_idle", 1, 8'd200, 1'b0, 1'b0);
    gap(3, "rm_gap", 1, 8'd200, 1'b0);

    // Preset change while running takes effect only at overflow
    start1 = 1'b0;
    cyc(1'b0, "pc_stop", 1, 8'd200, 1'b0, 1'b0);
    preset1 = 8'd250;
    cyc(1'b0, "pc_load", 1, 8'd250, 1'b0, 1'b0);
    start1 = 1'b1;
    cyc(1'b0, "pc_start", 1, 8'd250, 1'b0, 1'b0);
    cyc(1'b1, "pc_tick", 1, 8'd251, 1'b0, 1'b0);
    cyc(1'b1, "pc_tick", 1, 8'd252, 1'b0, 1'b0);
    preset1 = 8'd10;
    cyc(1'b1, "pc_tick", 1, 8'd253, 1'b0, 1'b0);
    cyc(1'b1, "pc_tick", 1, 8'd254, 1'b0, 1'b0);
    cyc(1'b1, "pc_tick", 1, 8'd255, 1'b0, 1'b0);
    cyc(1'b1, "pc_reload", 1, 8'd10, 1'b1, 1'b1);
    gap(2, "pc_gap", 1, 8'd10, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
